// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if
// Groups every signal between the writeback arbiter and its neighbours:
//   - ALU and load writeback requests with their valid/ready handshakes
//   - the registered register-file write port (writeEnable, writeAddr, dIn)
//   - the issue-stage hazard interface (issue_*, chk_addr*, busy*, pending)
//   - the sticky wb_err flag
// The slave modport is the arbiter's view.
// The master modport is the view of the surrounding pipeline / register file.
interface rf_wb_arbiter_if #(
  parameter int N = 16,
  parameter int M = 4,
  parameter int O = 16
);
  logic         alu_valid;
  logic         alu_ready;
  logic [M-1:0] alu_addr;
  logic [N-1:0] alu_data;

  logic         mem_valid;
  logic         mem_ready;
  logic [M-1:0] mem_addr;
  logic [N-1:0] mem_data;

  logic         writeEnable;
  logic [M-1:0] writeAddr;
  logic [N-1:0] dIn;

  logic         issue_valid;
  logic [M-1:0] issue_addr;
  logic         issue_ready;

  logic [M-1:0] chk_addr0;
  logic [M-1:0] chk_addr1;
  logic         busy0;
  logic         busy1;
  logic [O-1:0] pending;
  logic         wb_err;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  issue_valid, issue_addr, chk_addr0, chk_addr1,
    output alu_ready, mem_ready,
    output writeEnable, writeAddr, dIn,
    output issue_ready, busy0, busy1, pending, wb_err
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output issue_valid, issue_addr, chk_addr0, chk_addr1,
    input  alu_ready, mem_ready,
    input  writeEnable, writeAddr, dIn,
    input  issue_ready, busy0, busy1, pending, wb_err
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the register file's single write port between the ALU writeback
// path and the load-return path.
// Also keeps a per-register scoreboard of outstanding writes, which the
// issue stage uses to stall on RAW/WAW hazards.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - rf_wb_arbiter_if.slave, which carries:
//              - ALU and load requests, each with a valid/ready handshake
//              - the registered write port to the register file
//              - the issue/check hazard interface, the pending vector and wb_err
//
// Parameters:
//   N - data width
//   M - address width
//   O - number of registers (O must not exceed 2**M)
module rf_wb_arbiter #(
  parameter int N = 16,
  parameter int M = 4,
  parameter int O = 16
) (
  input logic            clk,
  input logic            rst_n,
  rf_wb_arbiter_if.slave bus
);

  // last_alu_q = 1 when the ALU won the most recent grant.
  // Reset clears it, so the ALU is favoured after reset.
  logic         last_alu_q, last_alu_d;
  logic         we_q, we_d;
  logic [M-1:0] waddr_q, waddr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [O-1:0] pending_q, pending_d;
  logic         wb_err_q, wb_err_d;

  logic         grant_alu, grant_mem, grant_any;
  logic [M-1:0] win_addr;
  logic [N-1:0] win_data;
  logic         issue_ready;
  logic         issue_fire;
  logic [O-1:0] issue_dec, set_vec, clr_vec, win_dec, chk0_dec, chk1_dec;

  // One-hot decode of a register address.
  // Addresses at or above O decode to all zeros, which gives three effects:
  //   - an issue to such an address sets nothing
  //   - a busy check on it reads 0
  //   - a writeback to it finds no pending bit, so it flags wb_err
  function automatic logic [O-1:0] decode(input logic [M-1:0] a);
    logic [O-1:0] d;
    d = '0;
    for (int i = 0; i < O; i++) begin
      if (a == M'(i)) d[i] = 1'b1;
    end
    return d;
  endfunction

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    grant_any = 1'b0;
    win_addr  = waddr_q;
    win_data  = wdata_q;

    // On a collision the requester not granted last time wins.
    grant_alu = bus.alu_valid & (~bus.mem_valid | ~last_alu_q);
    grant_mem = bus.mem_valid & (~bus.alu_valid |  last_alu_q);
    grant_any = grant_alu | grant_mem;

    if (grant_alu) begin
      win_addr = bus.alu_addr;
      win_data = bus.alu_data;
    end else if (grant_mem) begin
      win_addr = bus.mem_addr;
      win_data = bus.mem_data;
    end
  end

  always_comb begin
    issue_dec   = '0;
    set_vec     = '0;
    clr_vec     = '0;
    win_dec     = '0;
    chk0_dec    = '0;
    chk1_dec    = '0;
    issue_ready = 1'b0;
    issue_fire  = 1'b0;

    issue_dec = decode(bus.issue_addr);
    win_dec   = decode(win_addr);
    chk0_dec  = decode(bus.chk_addr0);
    chk1_dec  = decode(bus.chk_addr1);

    // issue_ready looks only at registered state.
    // A commit already in flight does not make the register available early.
    issue_ready = ~|(pending_q & issue_dec);
    issue_fire  = bus.issue_valid & issue_ready;

    if (issue_fire) set_vec = issue_dec;
    if (we_q)       clr_vec = decode(waddr_q);
  end

  always_comb begin
    last_alu_d = last_alu_q;
    we_d       = grant_any;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    pending_d  = pending_q;
    wb_err_d   = wb_err_q;

    if (grant_any) begin
      last_alu_d = grant_alu;
      waddr_d    = win_addr;
      wdata_d    = win_data;
    end

    // Clear first, then OR in the set.
    // If a new issue claims a register on the same edge its old write
    // commits, the new issue keeps the register marked pending.
    pending_d = (pending_q & ~clr_vec) | set_vec;

    // A writeback is legal only if its target is already pending or is
    // being claimed on this same edge.
    if (grant_any && ((win_dec & (pending_q | set_vec)) == '0)) begin
      wb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_alu_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      pending_q  <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      last_alu_q <= last_alu_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      pending_q  <= pending_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign bus.alu_ready   = grant_alu;
  assign bus.mem_ready   = grant_mem;
  assign bus.writeEnable = we_q;
  assign bus.writeAddr   = waddr_q;
  assign bus.dIn         = wdata_q;
  assign bus.issue_ready = issue_ready;
  assign bus.busy0       = |(pending_q & chk0_dec);
  assign bus.busy1       = |(pending_q & chk1_dec);
  assign bus.pending     = pending_q;
  assign bus.wb_err      = wb_err_q;

endmodule
